// File: rtl/dmem_bridge_pkg.sv
// Shared types for the data-memory bridge: FSM states and the write-buffer entry.
package dmem_bridge_pkg;

    localparam int DM_ADDR_W = 32;
    localparam int WB_ADDR_W = DM_ADDR_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        LD_REQ,
        LD_WAIT,
        ACK
    } state_e;

    // Buffered stores keep only the word address; byte position lives in be.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [31:0]          data;
        logic [3:0]           be;
    } wb_entry_t;

    function automatic logic [DM_ADDR_W-1:0] word_addr(input logic [WB_ADDR_W-1:0] a);
        return {a, 2'b00};
    endfunction

endpackage

// File: rtl/dmem_bridge_wb_fifo.sv
// Write buffer: synchronous FIFO of wb_entry_t, head visible combinationally.
// Push when full and pop when empty are dropped; count is the registered occupancy.
module wb_fifo
    import dmem_bridge_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  wb_entry_t                    push_dat_i,
    input  logic                         pop_i,
    output wb_entry_t                    head_dat_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: contents are only observed through a non-empty head.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/dmem_bridge.sv
// Core data-memory port to req/grant/rvalid bridge with a posted write buffer.
// Store acks one cycle after request unless the buffer is full; loads drain the buffer first.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int WB_DEPTH = 4,
    parameter int ADDR_W   = DM_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CpuRead,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddress,
    input  logic [31:0]       CpuWriteData,
    input  logic [3:0]        CpuByteEnable,
    output logic [31:0]       CpuReadData,
    output logic              CpuAck,
    output logic              Busy,
    output logic              MemReq,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemWData,
    output logic [3:0]        MemBe,
    input  logic              MemGnt,
    input  logic              MemRValid,
    input  logic [31:0]       MemRData
);
    state_e    state_q, state_d;
    logic [31:0] rdata_q;
    wb_entry_t wb_in, wb_head;
    logic      wb_push, wb_pop, wb_full, wb_empty, drain_sel;
    logic [$clog2(WB_DEPTH+1)-1:0] unused_wb_count;
    logic      unused_addr_lsb;

    assign unused_addr_lsb = ^CpuAddress[1:0];

    assign wb_in.addr = CpuAddress[ADDR_W-1:2];
    assign wb_in.data = CpuWriteData;
    assign wb_in.be   = CpuByteEnable;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .push_i     (wb_push),
        .push_dat_i (wb_in),
        .pop_i      (wb_pop),
        .head_dat_o (wb_head),
        .full_o     (wb_full),
        .empty_o    (wb_empty),
        .count_o    (unused_wb_count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Write wins over an (illegal) simultaneous read; full uses pre-pop occupancy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (CpuWrite) begin
                    if (CpuByteEnable == 4'b0 || !wb_full) state_d = ACK;
                end else if (CpuRead) begin
                    state_d = wb_empty ? LD_REQ : DRAIN;
                end
            end
            DRAIN:   if (wb_empty)  state_d = LD_REQ;
            LD_REQ:  if (MemGnt)    state_d = LD_WAIT;
            LD_WAIT: if (MemRValid) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_push   = (state_q == IDLE) && CpuWrite && (CpuByteEnable != 4'b0) && !wb_full;
        drain_sel = (state_q != LD_REQ) && (state_q != LD_WAIT) && !wb_empty;
        wb_pop    = drain_sel && MemGnt;
        MemReq    = 1'b0;
        MemWe     = 1'b0;
        MemAddr   = '0;
        MemWData  = '0;
        MemBe     = '0;
        if (state_q == LD_REQ) begin
            MemReq  = 1'b1;
            MemAddr = {CpuAddress[ADDR_W-1:2], 2'b00};
            MemBe   = CpuByteEnable;
        end else if (drain_sel) begin
            MemReq   = 1'b1;
            MemWe    = 1'b1;
            MemAddr  = word_addr(wb_head.addr);
            MemWData = wb_head.data;
            MemBe    = wb_head.be;
        end
        CpuAck = (state_q == ACK);
        Busy   = !wb_empty || (state_q != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                      rdata_q <= '0;
        else if (state_q == LD_WAIT && MemRValid)      rdata_q <= MemRData;
    end

    assign CpuReadData = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with a memory-transaction and ack scoreboard.
module tb_dmem_bridge;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CpuRead = 1'b0, CpuWrite = 1'b0;
    logic [31:0] CpuAddress = '0, CpuWriteData = '0;
    logic [3:0]  CpuByteEnable = '0;
    logic [31:0] CpuReadData;
    logic        CpuAck, Busy, MemReq, MemWe;
    logic [31:0] MemAddr, MemWData;
    logic [3:0]  MemBe;
    logic        MemGnt = 1'b0, MemRValid = 1'b0;
    logic [31:0] MemRData = '0;

    dmem_bridge #(.WB_DEPTH(4), .ADDR_W(32)) dut (
        .CLK(CLK), .RST(RST), .CpuRead(CpuRead), .CpuWrite(CpuWrite),
        .CpuAddress(CpuAddress), .CpuWriteData(CpuWriteData), .CpuByteEnable(CpuByteEnable),
        .CpuReadData(CpuReadData), .CpuAck(CpuAck), .Busy(Busy), .MemReq(MemReq),
        .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe),
        .MemGnt(MemGnt), .MemRValid(MemRValid), .MemRData(MemRData)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } mtx_t;
    typedef struct { logic ld; logic [31:0] data; } ack_t;

    mtx_t exp_mem[$];
    ack_t exp_ack[$];

    int checks = 0, errors = 0;
    int cyc = 0, ack_cyc = 0, rv_cyc = 0, lat = 0;
    logic ack_seen = 1'b0, rv_pend = 1'b0, force_rv = 1'b0;
    logic [31:0] rv_data = '0, rd_value = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were set at the preceding negedge; sample at negedge+1.
    task automatic step();
        mtx_t m;
        ack_t a;
        MemRValid = rv_pend || force_rv;
        if (MemRValid) begin
            MemRData = rv_data;
            rv_cyc   = cyc;
        end
        rv_pend  = 1'b0;
        ack_seen = 1'b0;
        #1;
        if (MemReq && MemGnt) begin
            chk("mem_txn_expected", 32'(exp_mem.size() != 0), 1);
            if (exp_mem.size() != 0) begin
                m = exp_mem.pop_front();
                chk("mem_we", MemWe, m.we);
                chk("mem_addr", MemAddr, m.addr);
                chk("mem_be", MemBe, m.be);
                if (m.we) chk("mem_wdata", MemWData, m.data);
            end
            if (!MemWe) begin
                rv_pend = 1'b1;
                rv_data = rd_value;
            end
        end
        if (CpuAck) begin
            ack_seen = 1'b1;
            ack_cyc  = cyc;
            chk("ack_expected", 32'(exp_ack.size() != 0), 1);
            if (exp_ack.size() != 0) begin
                a = exp_ack.pop_front();
                if (a.ld) begin
                    chk("ack_rdata", CpuReadData, a.data);
                    chk("ack_after_rvalid", 32'(cyc - rv_cyc), 1);
                end
            end
        end
        @(negedge CLK);
        cyc++;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be, output int latency);
        int start, n;
        if (be != 4'b0) exp_mem.push_back('{1'b1, {addr[31:2], 2'b00}, data, be});
        exp_ack.push_back('{1'b0, 32'h0});
        CpuWrite = 1'b1; CpuAddress = addr; CpuWriteData = data; CpuByteEnable = be;
        start = cyc; n = 0;
        do begin step(); n++; end while (!ack_seen && n < 50);
        chk("store_ack_seen", 32'(ack_seen), 1);
        latency = ack_cyc - start;
        CpuWrite = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [3:0] be,
                           input logic [31:0] value, output int latency);
        int start, n;
        rd_value = value;
        exp_mem.push_back('{1'b0, {addr[31:2], 2'b00}, 32'h0, be});
        exp_ack.push_back('{1'b1, value});
        CpuRead = 1'b1; CpuAddress = addr; CpuByteEnable = be;
        start = cyc; n = 0;
        do begin step(); n++; end while (!ack_seen && n < 50);
        chk("load_ack_seen", 32'(ack_seen), 1);
        latency = ack_cyc - start;
        CpuRead = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy && n < 50) begin step(); n++; end
        chk(tag, 32'(Busy), 0);
        chk({tag, "_sb_empty"}, 32'(exp_mem.size()), 0);
    endtask

    initial begin
        // Reset values while RST is held low
        #1;
        chk("rst_ack", CpuAck, 0);
        chk("rst_rdata", CpuReadData, 0);
        chk("rst_memreq", MemReq, 0);
        chk("rst_memwe", MemWe, 0);
        chk("rst_memaddr", MemAddr, 0);
        chk("rst_memwdata", MemWData, 0);
        chk("rst_membe", MemBe, 0);
        chk("rst_busy", Busy, 0);
        @(negedge CLK);
        RST = 1'b1;

        // Asynchronous reset mid-cycle with two stores buffered, during an ack
        do_store(32'h40, 32'h1111_1111, 4'hF, lat);
        CpuWrite = 1'b1; CpuAddress = 32'h44; CpuWriteData = 32'h2222_2222; CpuByteEnable = 4'hF;
        step();
        #1;
        chk("arst_pre_ack", CpuAck, 1);
        chk("arst_pre_memreq", MemReq, 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_memreq", MemReq, 0);
        chk("arst_ack", CpuAck, 0);
        chk("arst_busy", Busy, 0);
        CpuWrite = 1'b0;
        exp_mem.delete();
        exp_ack.delete();
        @(negedge CLK);
        RST = 1'b1;
        MemGnt = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("arst_post_busy", Busy, 0);
        chk("arst_post_memreq", MemReq, 0);
        MemGnt = 1'b0;

        // Posted store held on the port until granted
        do_store(32'h100, 32'hDEAD_BEEF, 4'hF, lat);
        chk("post_store_lat", lat, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_hold_req", MemReq, 1);
            chk("post_hold_we", MemWe, 1);
            chk("post_hold_addr", MemAddr, 32'h100);
            @(negedge CLK);
            cyc++;
        end
        MemGnt = 1'b1;
        step();
        MemGnt = 1'b0;
        wait_idle("post_idle");

        // Buffer full: fifth store waits for a pop, then one more cycle
        for (int i = 0; i < 4; i++) begin
            do_store(32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 4'hF, lat);
            chk("full_store_lat", lat, 1);
        end
        exp_mem.push_back('{1'b1, 32'h210, 32'hA4, 4'hF});
        exp_ack.push_back('{1'b0, 32'h0});
        CpuWrite = 1'b1; CpuAddress = 32'h210; CpuWriteData = 32'hA4; CpuByteEnable = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_ack", ack_seen, 0);
        end
        MemGnt = 1'b1;
        step();
        chk("full_no_ack_pop", ack_seen, 0);
        MemGnt = 1'b0;
        step();
        chk("full_no_ack_push", ack_seen, 0);
        step();
        chk("full_late_ack", ack_seen, 1);
        CpuWrite = 1'b0;
        MemGnt = 1'b1;
        wait_idle("full_drain");
        MemGnt = 1'b0;

        // Load behind two buffered stores; sub-word address is word-aligned on the port
        do_store(32'h10, 32'h0101_0101, 4'hF, lat);
        do_store(32'h14, 32'h0202_0202, 4'hF, lat);
        MemGnt = 1'b1;
        do_load(32'h16, 4'b1100, 32'h1234_5678, lat);
        chk("ld_rdata", CpuReadData, 32'h1234_5678);
        wait_idle("ld_idle");

        // Zero byte enable: acked, nothing written
        do_store(32'h300, 32'h5555_5555, 4'h0, lat);
        chk("be0_lat", lat, 1);
        wait_idle("be0_idle");

        // Minimum load latency with an empty buffer
        do_load(32'h80, 4'hF, 32'hCAFE_F00D, lat);
        chk("min_load_lat", lat, 3);
        chk("min_load_rdata", CpuReadData, 32'hCAFE_F00D);
        MemGnt = 1'b0;

        // Stray rvalid while idle
        force_rv = 1'b1; rv_data = 32'hFFFF_FFFF;
        step();
        force_rv = 1'b0;
        chk("spur_no_ack", ack_seen, 0);
        step();
        chk("spur_rdata", CpuReadData, 32'hCAFE_F00D);
        chk("spur_busy", Busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
Sits directly downstream of the core's data-memory port. It converts the core's level-style load/store requests into a req/grant/rvalid handshake toward a multi-cycle data memory. Stores are posted through a small write buffer so the core can continue. Loads drain the buffer first, then complete in order; the block returns data plus a one-cycle acknowledge that the core uses as its data-memory ack.

Parameters:
WB_DEPTH, 4, write-buffer entries; power of two, >= 2
ADDR_W, 32, byte address width

Ports:
CLK  in  1  clock
RST  in  1  asynchronous, active-low reset
CpuRead  in  1  load request; held until CpuAck
CpuWrite  in  1  store request; held until CpuAck
CpuAddress  in  ADDR_W  byte address
CpuWriteData  in  32  store data (lane-aligned)
CpuByteEnable  in  4  byte lanes
CpuReadData  out  32  registered load data
CpuAck  out  1  one-cycle completion pulse
Busy  out  1  FIFO non-empty or FSM not IDLE
MemReq  out  1  memory request valid
MemWe  out  1  1 = write, 0 = read
MemAddr  out  ADDR_W  word address {addr[ADDR_W-1:2],2'b00}
MemWData  out  32  write data
MemBe  out  4  byte enables
MemGnt  in  1  request accepted at this edge
MemRValid  in  1  read data valid; at least one cycle after MemGnt
MemRData  in  32  read data

Behaviour:
- Reset (RST=0, async):
  - FIFO emptied; buffered stores are discarded.
  - FSM forced to IDLE.
  - CpuAck=0, CpuReadData=0, MemReq=0, MemWe=0, MemAddr=0, MemWData=0, MemBe=0, Busy=0.
- FSM states: IDLE, DRAIN, LD_REQ, LD_WAIT, ACK.
- Requests are ignored while in ACK, so the core can drop its request during the ack cycle.
- Store, in IDLE with CpuWrite=1:
  - Count < WB_DEPTH (registered count, sampled before any same-edge pop): push {addr[31:2], data, be}, go to ACK. CpuAck=1 for that single cycle, then return to IDLE.
  - Count == WB_DEPTH: stay in IDLE, no ack. A concurrent pop does not admit the push in the same cycle; the push is accepted next cycle.
  - CpuByteEnable == 0: acked, nothing pushed.
- Store priority: CpuRead and CpuWrite both 1 is illegal. Write takes priority and the read is ignored.
- Load, in IDLE with CpuRead=1:
  - FIFO non-empty: go to DRAIN, stay until empty, then go to LD_REQ.
  - FIFO empty: go directly to LD_REQ on the next edge.
  - LD_REQ: MemReq=1, MemWe=0, MemAddr and MemBe taken from Cpu inputs. Hold until MemGnt=1, then go to LD_WAIT.
  - LD_WAIT: on MemRValid, CpuReadData <= MemRData, then go to ACK.
- Drain port:
  - Whenever the FSM is not in LD_REQ/LD_WAIT and the FIFO is non-empty, present the head: MemReq=1, MemWe=1, plus addr/data/be.
  - Pop on an edge with MemGnt=1.
  - Stores leave in push order.
- Memory port outputs are combinational from FIFO head or Cpu inputs.
- MemRValid outside LD_WAIT: ignored; CpuReadData unchanged.
- MemGnt while MemReq=0: ignored.
- Minimum load latency: CpuRead sampled in IDLE (cycle 0), LD_REQ with grant (cycle 1), LD_WAIT with rvalid (cycle 2), CpuAck=1 (cycle 3).
- Store throughput: one store per 2 cycles.
- FIFO pointers wrap modulo WB_DEPTH; count width is $clog2(WB_DEPTH+1).

Decomposition:
- Package dmem_bridge_pkg:
  - state enum (IDLE, DRAIN, LD_REQ, LD_WAIT, ACK).
  - wb_entry_t struct {addr[ADDR_W-3:0], data[31:0], be[3:0]}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty/count. It uses the same CLK and RST.

Test Plan:
- Reset: two stores buffered, MemGnt=0, drop RST mid-cycle → MemReq, CpuAck and Busy go 0 immediately; after release, count=0 and no writes are issued.
- Posted store: write 0x100/0xDEADBEEF/4'hF with MemGnt=0 → CpuAck pulse the cycle after request. MemReq=1, MemWe=1, MemAddr=0x100 held until MemGnt.
- Full: WB_DEPTH=4, MemGnt=0, five stores → first four acked. The fifth is acked only after the cycle following the first MemGnt pop; memory sees all five in order.
- Load after stores: stores to 0x10 and 0x14, then load 0x16 with be 4'b1100 → both writes granted before the read. Read has MemAddr=0x14, MemBe=4'b1100. MemRData=0x12345678 gives CpuReadData=0x12345678 with CpuAck one cycle after MemRValid.
- Minimum load, FIFO empty, immediate grant, rvalid next cycle → CpuAck at cycle 3.
- Spurious MemRValid=1 with MemRData=0xFFFFFFFF in IDLE → CpuReadData unchanged, no CpuAck.
